// File: rtl/rv32i_types.sv
// Shared RV32I types and helpers for the memory-op address path.
package rv32i_types;

    // RV32I load/store funct3 size encodings (low two bits carry the size)
    localparam logic [2:0] MEM_B = 3'b000;
    localparam logic [2:0] MEM_H = 3'b001;
    localparam logic [2:0] MEM_W = 3'b010;

    // Field widths of a scheduler entry; agu_sched parameters default to these
    localparam int SCHED_ROB_W  = 5;
    localparam int SCHED_PREG_W = 6;

    typedef struct packed {
        logic                    valid;
        logic                    rdy;
        logic [SCHED_ROB_W-1:0]  rob_id;
        logic                    is_store;
        logic [2:0]              funct3;
        logic [SCHED_PREG_W-1:0] base_preg;
        logic [31:0]             base_val;
        logic [31:0]             imm;
    } agu_sched_entry_t;

    // Access-size alignment check; size code 11 has no legal alignment
    function automatic logic mem_misaligned(input logic [2:0] funct3,
                                            input logic [31:0] addr);
        logic r;
        case (funct3[1:0])
            MEM_B[1:0]: r = 1'b0;
            MEM_H[1:0]: r = addr[0];
            MEM_W[1:0]: r = |addr[1:0];
            default:    r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/agu.sv
// Address generation unit: 32-bit modulo add of base and offset.
module agu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_mem_op,
    output logic [31:0] f
);

    // Carry out of bit 31 is dropped; idle unit drives zero
    always_comb begin
        f = is_mem_op ? (a + b) : 32'h0;
    end

endmodule

// File: rtl/agu_sched.sv
// Age-ordered load/store scheduler feeding a single AGU, with CDB wakeup
// and a valid/ready output register toward the LSQ.
module agu_sched
    import rv32i_types::*;
#(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = SCHED_ROB_W,
    parameter int PREG_W    = SCHED_PREG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [ROB_IDX_W-1:0] disp_rob_id,
    input  logic                 disp_is_store,
    input  logic [2:0]           disp_funct3,
    input  logic [PREG_W-1:0]    disp_base_preg,
    input  logic                 disp_base_rdy,
    input  logic [31:0]          disp_base_val,
    input  logic [31:0]          disp_imm,
    input  logic                 cdb_valid,
    input  logic [PREG_W-1:0]    cdb_preg,
    input  logic [31:0]          cdb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB_IDX_W-1:0] out_rob_id,
    output logic                 out_is_store,
    output logic [2:0]           out_funct3,
    output logic [31:0]          out_addr,
    output logic                 out_misaligned
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    agu_sched_entry_t ent     [DEPTH];
    agu_sched_entry_t ent_wk  [DEPTH];
    agu_sched_entry_t ent_sh  [DEPTH];
    agu_sched_entry_t ent_nxt [DEPTH];
    agu_sched_entry_t new_ent;

    logic [CNT_W-1:0] count, count_nxt, wr_pos;
    logic [IDX_W-1:0] sel_idx;
    logic             has_cand, issue, disp_fire;
    logic [31:0]      agu_a, agu_b, agu_f;
    logic             agu_op;

    assign disp_ready = (count != CNT_W'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready;
    assign issue      = has_cand && (!out_valid || out_ready);

    // Oldest ready entry: scan from the top so the lowest index wins
    always_comb begin
        has_cand = 1'b0;
        sel_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent[i].valid && ent[i].rdy) begin
                has_cand = 1'b1;
                sel_idx  = IDX_W'(i);
            end
        end
    end

    // AGU operands are zeroed when nothing issues
    always_comb begin
        agu_op = issue;
        agu_a  = issue ? ent[sel_idx].base_val : 32'h0;
        agu_b  = issue ? ent[sel_idx].imm      : 32'h0;
    end

    agu u_agu (
        .a         (agu_a),
        .b         (agu_b),
        .is_mem_op (agu_op),
        .f         (agu_f)
    );

    // Incoming entry; a same-cycle CDB hit on its tag makes it ready at once
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.rob_id    = disp_rob_id;
        new_ent.is_store  = disp_is_store;
        new_ent.funct3    = disp_funct3;
        new_ent.base_preg = disp_base_preg;
        new_ent.imm       = disp_imm;
        new_ent.rdy       = disp_base_rdy;
        new_ent.base_val  = disp_base_val;
        if (!disp_base_rdy && cdb_valid && (cdb_preg == disp_base_preg)) begin
            new_ent.rdy      = 1'b1;
            new_ent.base_val = cdb_data;
        end
    end

    // Wakeup in place, then compact over the issued slot, then append
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_wk[i] = ent[i];
            if (ent[i].valid && !ent[i].rdy && cdb_valid && (ent[i].base_preg == cdb_preg)) begin
                ent_wk[i].rdy      = 1'b1;
                ent_wk[i].base_val = cdb_data;
            end
        end
        ent_sh[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_sh[i] = ent_wk[i+1];
        end
        wr_pos = count - CNT_W'(issue);
        for (int i = 0; i < DEPTH; i++) begin
            ent_nxt[i] = (issue && (i >= int'(sel_idx))) ? ent_sh[i] : ent_wk[i];
            if (disp_fire && (CNT_W'(i) == wr_pos)) begin
                ent_nxt[i] = new_ent;
            end
        end
        count_nxt = count + CNT_W'(disp_fire) - CNT_W'(issue);
    end

    // Queue state; flush drops every entry regardless of other activity
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            count <= count_nxt;
            for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
        end
    end

    // Output register: load on issue, drop on accept, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_rob_id     <= '0;
            out_is_store   <= 1'b0;
            out_funct3     <= 3'b0;
            out_addr       <= 32'h0;
            out_misaligned <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid      <= 1'b1;
            out_rob_id     <= ent[sel_idx].rob_id;
            out_is_store   <= ent[sel_idx].is_store;
            out_funct3     <= ent[sel_idx].funct3;
            out_addr       <= agu_f;
            out_misaligned <= mem_misaligned(ent[sel_idx].funct3, agu_f);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_agu_sched.sv
// Self-checking bench for agu_sched: directed table, corner sequences and
// random traffic compared every cycle against a queue-based reference model.
module tb_agu_sched;
    localparam int DEPTH = 4;

    logic        clk, rst, flush;
    logic        disp_valid, disp_ready, disp_is_store, disp_base_rdy;
    logic [4:0]  disp_rob_id;
    logic [2:0]  disp_funct3;
    logic [5:0]  disp_base_preg;
    logic [31:0] disp_base_val, disp_imm;
    logic        cdb_valid;
    logic [5:0]  cdb_preg;
    logic [31:0] cdb_data;
    logic        out_valid, out_ready, out_is_store, out_misaligned;
    logic [4:0]  out_rob_id;
    logic [2:0]  out_funct3;
    logic [31:0] out_addr;

    agu_sched #(.DEPTH(DEPTH), .ROB_IDX_W(5), .PREG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob_id(disp_rob_id),
        .disp_is_store(disp_is_store), .disp_funct3(disp_funct3),
        .disp_base_preg(disp_base_preg), .disp_base_rdy(disp_base_rdy),
        .disp_base_val(disp_base_val), .disp_imm(disp_imm),
        .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob_id(out_rob_id),
        .out_is_store(out_is_store), .out_funct3(out_funct3),
        .out_addr(out_addr), .out_misaligned(out_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: plain queue, oldest at the front
    typedef struct {
        logic [4:0]  rob;
        logic        st;
        logic [2:0]  f3;
        logic [5:0]  preg;
        logic        rdy;
        logic [31:0] val;
        logic [31:0] imm;
    } m_ent_t;
    m_ent_t      m_q[$];
    logic        m_ov, m_st, m_mis;
    logic [4:0]  m_rob;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (f3[1:0] == 2'b11) return 1'b1;
        sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    task automatic model_step();
        int sel;
        bit iss, acc;
        m_ent_t ne;
        if (rst) begin
            m_q.delete();
            m_ov = 0; m_addr = 0; m_rob = 0; m_st = 0; m_f3 = 0; m_mis = 0;
        end else if (flush) begin
            m_q.delete();
            m_ov = 0;
        end else begin
            sel = -1;
            foreach (m_q[i]) if (sel < 0 && m_q[i].rdy) sel = i;
            iss = (sel >= 0) && (!m_ov || out_ready);
            acc = disp_valid && (m_q.size() < DEPTH);
            if (iss) begin
                m_addr = m_q[sel].val + m_q[sel].imm;
                m_rob  = m_q[sel].rob;
                m_st   = m_q[sel].st;
                m_f3   = m_q[sel].f3;
                m_mis  = ref_mis(m_f3, m_addr);
                m_ov   = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            foreach (m_q[i]) begin
                if (cdb_valid && !m_q[i].rdy && m_q[i].preg == cdb_preg) begin
                    m_q[i].rdy = 1;
                    m_q[i].val = cdb_data;
                end
            end
            if (iss) m_q.delete(sel);
            if (acc) begin
                ne.rob  = disp_rob_id;
                ne.st   = disp_is_store;
                ne.f3   = disp_funct3;
                ne.preg = disp_base_preg;
                ne.imm  = disp_imm;
                ne.rdy  = disp_base_rdy || (cdb_valid && cdb_preg == disp_base_preg);
                ne.val  = disp_base_rdy ? disp_base_val : cdb_data;
                m_q.push_back(ne);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: advance model, let DUT take the edge, compare at negedge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("model disp_ready", disp_ready, (m_q.size() != DEPTH));
        chk("model out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("model out_addr", out_addr, m_addr);
            chk("model out_rob_id", out_rob_id, m_rob);
            chk("model out_is_store", out_is_store, m_st);
            chk("model out_funct3", out_funct3, m_f3);
            chk("model out_misaligned", out_misaligned, m_mis);
        end
    endtask

    task automatic idle();
        disp_valid = 0; cdb_valid = 0; flush = 0;
    endtask

    task automatic disp(input logic [4:0] rob, input logic st, input logic [2:0] f3,
                        input logic [5:0] preg, input logic rdy,
                        input logic [31:0] base, input logic [31:0] imm);
        disp_valid = 1; disp_rob_id = rob; disp_is_store = st; disp_funct3 = f3;
        disp_base_preg = preg; disp_base_rdy = rdy; disp_base_val = base; disp_imm = imm;
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        st;
        logic [31:0] exp_addr;
        logic        exp_mis;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{32'h0000_1000, 32'h8, 3'b010, 1'b0, 32'h0000_1008, 1'b0};
        tbl[1] = '{32'hFFFF_FFFC, 32'h8, 3'b010, 1'b0, 32'h0000_0004, 1'b0};
        tbl[2] = '{32'h0000_1000, 32'h1, 3'b001, 1'b0, 32'h0000_1001, 1'b1};
        tbl[3] = '{32'h0000_1000, 32'h2, 3'b010, 1'b1, 32'h0000_1002, 1'b1};
        tbl[4] = '{32'h0000_1003, 32'h0, 3'b000, 1'b0, 32'h0000_1003, 1'b0};
        tbl[5] = '{32'h0000_2000, 32'h0, 3'b011, 1'b0, 32'h0000_2000, 1'b1};
        tbl[6] = '{32'h0000_0010, 32'h2, 3'b101, 1'b0, 32'h0000_0012, 1'b0};

        rst = 1; out_ready = 1; cdb_preg = 0; cdb_data = 0;
        disp(0, 0, 0, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        tick(); tick();
        chk("reset disp_ready", disp_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_addr", out_addr, 0);
        rst = 0;
        tick();

        // Single ready ops: result two edges after dispatch is presented
        for (int i = 0; i < 7; i++) begin
            disp(5'(i), tbl[i].st, tbl[i].f3, 6'd1, 1'b1, tbl[i].base, tbl[i].imm);
            tick();
            idle();
            chk("vec latency out_valid", out_valid, 0);
            tick();
            chk("vec out_valid", out_valid, 1);
            chk("vec out_addr", out_addr, tbl[i].exp_addr);
            chk("vec out_misaligned", out_misaligned, tbl[i].exp_mis);
            chk("vec out_is_store", out_is_store, tbl[i].st);
            chk("vec out_rob_id", out_rob_id, i);
        end
        tick();

        // Older unready A is overtaken by younger ready B
        disp(5'd1, 0, 3'b010, 6'd5, 1'b0, 32'h0, 32'h10);
        tick();
        disp(5'd2, 0, 3'b010, 6'd9, 1'b1, 32'h100, 32'h4);
        tick();
        idle();
        tick();
        chk("ooo first rob", out_rob_id, 2);
        chk("ooo first addr", out_addr, 32'h104);
        cdb_valid = 1; cdb_preg = 6'd5; cdb_data = 32'h2000;
        tick();
        idle();
        tick();
        chk("ooo second valid", out_valid, 1);
        chk("ooo second rob", out_rob_id, 1);
        chk("ooo second addr", out_addr, 32'h2010);
        tick();

        // Same-cycle CDB bypass into a new dispatch
        disp(5'd3, 0, 3'b010, 6'd7, 1'b0, 32'h0, 32'h0);
        cdb_valid = 1; cdb_preg = 6'd7; cdb_data = 32'h3000;
        tick();
        idle();
        tick();
        chk("bypass valid", out_valid, 1);
        chk("bypass addr", out_addr, 32'h3000);
        tick();

        // Fill, overflow attempt, then backpressure hold
        for (int i = 0; i < 4; i++) begin
            disp(5'(10 + i), 0, 3'b010, 6'd20, 1'b0, 32'h0, 32'(4 * i));
            tick();
        end
        chk("full disp_ready", disp_ready, 0);
        disp(5'd14, 0, 3'b010, 6'd20, 1'b0, 32'h0, 32'h0);
        tick();
        chk("overflow disp_ready", disp_ready, 0);
        idle();
        out_ready = 0;
        cdb_valid = 1; cdb_preg = 6'd20; cdb_data = 32'h4000;
        tick();
        idle();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold out_valid", out_valid, 1);
            chk("hold out_rob_id", out_rob_id, 10);
            chk("hold out_addr", out_addr, 32'h4000);
            tick();
        end
        chk("hold disp_ready", disp_ready, 1);
        out_ready = 1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("drain rob", out_rob_id, 10 + i);
            chk("drain addr", out_addr, 32'h4000 + 4 * i);
        end
        tick();
        chk("drain empty", out_valid, 0);

        // Flush with queued entries and a held output
        out_ready = 0;
        disp(5'd20, 0, 3'b000, 6'd1, 1'b1, 32'h55, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            disp(5'(21 + i), 0, 3'b010, 6'd30, 1'b0, 32'h0, 32'h0);
            tick();
        end
        idle();
        chk("preflush out_valid", out_valid, 1);
        flush = 1;
        tick();
        flush = 0;
        chk("flush out_valid", out_valid, 0);
        chk("flush disp_ready", disp_ready, 1);
        out_ready = 1;
        cdb_valid = 1; cdb_preg = 6'd30; cdb_data = 32'h1;
        tick();
        idle();
        tick();
        chk("post flush out_valid", out_valid, 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            disp_valid     = ($urandom_range(0, 1) == 1);
            disp_rob_id    = 5'($urandom_range(0, 31));
            disp_is_store  = 1'($urandom_range(0, 1));
            disp_funct3    = 3'($urandom_range(0, 7));
            disp_base_preg = 6'($urandom_range(0, 3));
            disp_base_rdy  = ($urandom_range(0, 2) == 0);
            disp_base_val  = $urandom;
            disp_imm       = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7));
            cdb_valid      = ($urandom_range(0, 1) == 1);
            cdb_preg       = 6'($urandom_range(0, 3));
            cdb_data       = $urandom;
            out_ready      = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 49) == 0);
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;
        idle();
        out_ready = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/agu_sched.md
# agu_sched

Memory-op address scheduler for the out-of-order core. It holds dispatched loads and stores until their base register is available, then picks the oldest ready entry each cycle and issues it to the single shared `agu`. It registers the computed effective address, together with a misalignment flag, toward the load/store queue using a valid/ready handshake. It sits between dispatch/rename and the LSQ, listening on the CDB for operand wakeup.

## Interface
Parameters:
- `DEPTH`, 4: number of scheduler entries (power of two, ≥2).
- `ROB_IDX_W`, 5: ROB index width.
- `PREG_W`, 6: physical register tag width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  squash all entries and the output register.
- `disp_valid`  in  1  dispatch request.
- `disp_ready`  out  1  scheduler can accept a dispatch.
- `disp_rob_id`  in  ROB_IDX_W  ROB index of the op.
- `disp_is_store`  in  1  1 = store, 0 = load.
- `disp_funct3`  in  3  RV32I memory funct3.
- `disp_base_preg`  in  PREG_W  base (rs1) physical tag.
- `disp_base_rdy`  in  1  base value already valid.
- `disp_base_val`  in  32  base value, meaningful when `disp_base_rdy`.
- `disp_imm`  in  32  sign-extended offset.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_preg`  in  PREG_W  broadcast tag.
- `cdb_data`  in  32  broadcast value.
- `out_valid`  out  1  address result valid.
- `out_ready`  in  1  LSQ accepts the result.
- `out_rob_id`  out  ROB_IDX_W  ROB index of the result.
- `out_is_store`  out  1  store flag of the result.
- `out_funct3`  out  3  funct3 of the result.
- `out_addr`  out  32  effective address.
- `out_misaligned`  out  1  address violates the access-size alignment.

## Operation
- Queue organisation:
  - Entries form a compacting, age-ordered queue: slot 0 is the oldest, valid slots are 0..count-1.
  - New entries are written at slot `count`.
- Dispatch:
  - Accepted when `disp_valid && disp_ready`.
  - `disp_ready = (count != DEPTH)`, taken from registered state. An issue in the same cycle does not raise `disp_ready`.
- Wakeup:
  - Every valid, not-ready entry whose tag equals `cdb_preg` while `cdb_valid` captures `cdb_data` and becomes ready.
  - Bypass: a dispatch whose `disp_base_preg` matches a same-cycle CDB broadcast, with `disp_base_rdy=0`, is written already ready holding `cdb_data`.
- Selection:
  - Candidate = lowest-index ready entry.
  - Issue fires when a candidate exists and `(!out_valid || out_ready)`.
- Issue:
  - Drive `agu` with a = base, b = imm, `is_mem_op=1`.
  - On the clock edge, load the output register with `agu` f, the entry's rob_id, is_store and funct3.
  - Remove the entry; higher slots shift down by one.
  - When not issuing, `is_mem_op=0` and both operands = 0.
- Arithmetic: 32-bit unsigned add, modulo 2^32. The carry out is discarded.
- Misalignment, from `funct3[1:0]`:
  - 00 (byte): never misaligned.
  - 01 (half): misaligned when addr[0] ≠ 0.
  - 10 (word): misaligned when addr[1:0] ≠ 0.
  - 11: always flagged.
- Output hold: the output register holds stable while `out_valid && !out_ready`.
- Flush:
  - count←0 and out_valid←0 on the next edge.
  - Flush wins over a same-cycle dispatch, issue and wakeup.

## Timing
- Reset values: count=0, every entry valid=0, `out_valid=0`, `out_addr=0`, `out_rob_id=0`, `out_is_store=0`, `out_funct3=0`, `out_misaligned=0`, `disp_ready=1`.
- Latency:
  - A ready op dispatched at edge N is selectable in cycle N+1 and shows `out_valid` after edge N+2.
  - A not-ready op is selectable the cycle after its CDB capture.
- Throughput: one issue per cycle with `out_ready` held high.
- Simultaneous events:
  - Issue plus dispatch: the new entry lands at slot count-1 after compaction.
  - Issue of slot k plus CDB wakeup of slot j>k: the wakeup is applied to the shifted slot j-1.
- Reset or flush mid-operation discards all state regardless of handshake; no partial result is emitted.

## Structure
- Add `agu_sched_entry_t` (valid, rdy, rob_id, is_store, funct3, base_preg, base_val, imm) to `rv32i_types`.
- Add the funct3 size constants `MEM_B`/`MEM_H`/`MEM_W` to `rv32i_types`.
- Sub-module: one instance of the existing `agu`. All other logic is flat in `agu_sched`.

## Test plan
- Reset: hold `rst=1` for 2 cycles → `disp_ready=1`, `out_valid=0`, `out_addr=0`.
- Ready dispatch: lw, base 0x1000, imm 0x8 → `out_valid` 2 cycles later, `out_addr=0x1008`, `out_misaligned=0`. Wrap case: base 0xFFFFFFFC, imm 0x8 → `out_addr=0x4`.
- Out-of-order wakeup:
  - A (preg 5, not ready) dispatched, then B ready → B's result comes out first.
  - Then CDB preg 5 = 0x2000 with A's imm 0x10 → A result `out_addr=0x2010`.
- Bypass: dispatch with `base_rdy=0`, preg 7, in the same cycle as CDB preg 7 = 0x3000, imm 0 → `out_addr=0x3000`, no further wakeup needed.
- Full and backpressure:
  - 4 unready dispatches → `disp_ready=0`; a 5th `disp_valid` is ignored.
  - With `out_ready=0`, the output fields stay stable over 5 cycles and the remaining entries stay queued.
- Flush and alignment:
  - `flush` with 3 entries plus a pending output → next cycle `out_valid=0`, `disp_ready=1`.
  - lh to 0x1001 → `out_misaligned=1`.
  - sw to 0x1002 → `out_misaligned=1`, `out_is_store=1`.
